mul_div_row_seq: RTL and testbench

- Iterative sequencer that reuses one row of array cells over WIDTH cycles.
- Performs unsigned WIDTH x WIDTH multiplication, or unsigned WIDTH / WIDTH non-restoring division.
- Owns the accumulator and quotient/multiplier shift registers, the row counter and the operation state machine.
- Drives the row's X, Y_ROW, P and MUL_BAR controls, and captures the row's sum outputs every cycle.

---
 rtl/mul_div_row_seq_pkg.sv | 20 ++
 rtl/mul_div_row.sv | 34 +++
 rtl/mul_div_row_seq.sv | 198 +++++++++++++++++++
 tb/tb_mul_div_row_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_row_seq_pkg.sv
// Shared definitions for the row-reusing multiply/divide sequencer and its row.
package mul_div_row_seq_pkg;

    // Operand width used when a parent does not override WIDTH.
    localparam int DEFAULT_WIDTH = 4;

    // Operation select as carried on MUL_BAR.
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Operation state machine.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mul_div_row.sv
// One row of WIDTH+1 add/subtract cells:
//   sum = in_prev + (y_row ? (p ? -x : x) : 0), modulo 2^(WIDTH+1).
// Subtraction is done as in_prev + ~x + 1, the +1 entering as carry into cell 0.
module mul_div_row
    import mul_div_row_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic             y_row,
    input  logic             p,
    input  logic [WIDTH:0]   in_prev,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH:0] x_ext;
    logic [WIDTH:0] b;
    logic [WIDTH:0] carry;

    // x is zero-extended so the top cell only ever sees the sign of -x.
    assign x_ext    = {1'b0, x};
    assign b        = (y_row ? x_ext : '0) ^ {(WIDTH + 1){y_row & p}};
    assign carry[0] = y_row & p;

    // Ripple chain of full-adder cells; the top cell's carry-out is the
    // discarded 2^(WIDTH+1) term, so it is never generated.
    for (genvar i = 0; i <= WIDTH; i++) begin : g_cell
        assign sum[i] = in_prev[i] ^ b[i] ^ carry[i];
        if (i < WIDTH) begin : g_carry
            assign carry[i+1] = (in_prev[i] & b[i]) | (carry[i] & (in_prev[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/mul_div_row_seq.sv
// Iterative sequencer that reuses one external add/subtract row for WIDTH
// cycles: unsigned shift-add multiply, or unsigned non-restoring divide with
// a single fixed restore cycle so both latencies are constant.
module mul_div_row_seq
    import mul_div_row_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             MUL_BAR,
    input  logic [WIDTH-1:0] X_IN,
    input  logic [WIDTH-1:0] Y_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV_ZERO,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic [WIDTH-1:0] RESULT_LO,
    output logic [WIDTH-1:0] ROW_X,
    output logic             ROW_Y,
    output logic             ROW_P,
    output logic             ROW_MUL_BAR,
    output logic [WIDTH:0]   ROW_IN_PREV,
    input  logic [WIDTH:0]   ROW_SUM
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_next;

    // Operands captured when START is accepted.
    logic [WIDTH-1:0] x_reg, y_reg;
    logic             mul_bar_reg;
    logic             capture;

    // Working registers: accumulator (one guard/sign bit), quotient/multiplier
    // shift register, previous quotient bit (selects next add/subtract), count.
    logic [WIDTH:0]   acc, acc_next;
    logic [WIDTH-1:0] q, q_next;
    logic             pq, pq_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    // Registered results and divide-by-zero flag.
    logic [WIDTH-1:0] res_hi, res_hi_next;
    logic [WIDTH-1:0] res_lo, res_lo_next;
    logic             div_zero, div_zero_next;

    // Non-restoring quotient bit: 1 when the new partial remainder is non-negative.
    logic             q_bit;
    assign q_bit = ~ROW_SUM[WIDTH];

    // State, working and result registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: every register here is assigned with <= so all of them update
        // from the same pre-edge values; a blocking = would let later
        // statements see already-updated values and change the hardware.
        if (RST) begin
            state       <= ST_IDLE;
            x_reg       <= '0;
            y_reg       <= '0;
            mul_bar_reg <= 1'b0;
            acc         <= '0;
            q           <= '0;
            pq          <= 1'b0;
            cnt         <= '0;
            res_hi      <= '0;
            res_lo      <= '0;
            div_zero    <= 1'b0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            q        <= q_next;
            pq       <= pq_next;
            cnt      <= cnt_next;
            res_hi   <= res_hi_next;
            res_lo   <= res_lo_next;
            div_zero <= div_zero_next;
            if (capture) begin
                x_reg       <= X_IN;
                y_reg       <= Y_IN;
                mul_bar_reg <= MUL_BAR;
            end
        end
    end

    // Next-state, working-register update and result capture.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_next    = state;
        acc_next      = acc;
        q_next        = q;
        pq_next       = pq;
        cnt_next      = cnt;
        res_hi_next   = res_hi;
        res_lo_next   = res_lo;
        div_zero_next = div_zero;
        capture       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (START) begin
                    capture       = 1'b1;
                    div_zero_next = 1'b0;
                    state_next    = ST_LOAD;
                end
            end

            ST_LOAD: begin
                acc_next = '0;
                q_next   = y_reg;
                cnt_next = '0;
                pq_next  = 1'b1;
                if (mul_bar_reg == OP_DIV && x_reg == '0) begin
                    div_zero_next = 1'b1;
                    res_hi_next   = y_reg;
                    res_lo_next   = '1;
                    state_next    = ST_DONE;
                end else begin
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                if (mul_bar_reg == OP_MUL) begin
                    // {ACC, Q} <= {ROW_SUM, Q} >> 1
                    acc_next = {1'b0, ROW_SUM[WIDTH:1]};
                    q_next   = {ROW_SUM[0], q[WIDTH-1:1]};
                end else begin
                    acc_next = ROW_SUM;
                    q_next   = {q[WIDTH-2:0], q_bit};
                    pq_next  = q_bit;
                end
                cnt_next = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    if (mul_bar_reg == OP_MUL) begin
                        res_hi_next = acc_next[WIDTH-1:0];
                        res_lo_next = q_next;
                        state_next  = ST_DONE;
                    end else begin
                        state_next = ST_FIX;
                    end
                end
            end

            ST_FIX: begin
                // Row adds X back only when the remainder went negative.
                acc_next    = ROW_SUM;
                res_hi_next = ROW_SUM[WIDTH-1:0];
                res_lo_next = q;
                state_next  = ST_DONE;
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Row controls: only RUN and FIX present a live operation to the row.
    always_comb begin
        ROW_Y       = 1'b0;
        ROW_P       = 1'b0;
        ROW_IN_PREV = '0;
        case (state)
            ST_RUN: begin
                if (mul_bar_reg == OP_MUL) begin
                    ROW_Y       = q[0];
                    ROW_IN_PREV = acc;
                end else begin
                    ROW_Y       = 1'b1;
                    ROW_P       = pq;
                    ROW_IN_PREV = {acc[WIDTH-1:0], q[WIDTH-1]};
                end
            end
            ST_FIX: begin
                ROW_Y       = acc[WIDTH];
                ROW_IN_PREV = acc;
            end
            default: ;
        endcase
    end

    assign BUSY        = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_FIX);
    assign DONE        = (state == ST_DONE);
    assign DIV_ZERO    = div_zero;
    assign RESULT_HI   = res_hi;
    assign RESULT_LO   = res_lo;
    assign ROW_X       = x_reg;
    assign ROW_MUL_BAR = mul_bar_reg;

endmodule

// File: tb/tb_mul_div_row_seq.sv
// Bench for mul_div_row_seq wired to mul_div_row. A cycle-level reference
// model (plain arithmetic on the operands, counted latency) is checked
// against the DUT on every falling edge; directed operations also pin
// hand-computed results and latencies.
module tb_mul_div_row_seq;
    import mul_div_row_seq_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic         MUL_BAR;
    logic [W-1:0] X_IN;
    logic [W-1:0] Y_IN;
    logic         BUSY;
    logic         DONE;
    logic         DIV_ZERO;
    logic [W-1:0] RESULT_HI;
    logic [W-1:0] RESULT_LO;
    logic [W-1:0] ROW_X;
    logic         ROW_Y;
    logic         ROW_P;
    logic         ROW_MUL_BAR;
    logic [W:0]   ROW_IN_PREV;
    logic [W:0]   ROW_SUM;

    int n_pass  = 0;
    int n_total = 0;

    mul_div_row_seq #(.WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .MUL_BAR    (MUL_BAR),
        .X_IN       (X_IN),
        .Y_IN       (Y_IN),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .DIV_ZERO   (DIV_ZERO),
        .RESULT_HI  (RESULT_HI),
        .RESULT_LO  (RESULT_LO),
        .ROW_X      (ROW_X),
        .ROW_Y      (ROW_Y),
        .ROW_P      (ROW_P),
        .ROW_MUL_BAR(ROW_MUL_BAR),
        .ROW_IN_PREV(ROW_IN_PREV),
        .ROW_SUM    (ROW_SUM)
    );

    mul_div_row #(.WIDTH(W)) row (
        .x      (ROW_X),
        .y_row  (ROW_Y),
        .p      (ROW_P),
        .in_prev(ROW_IN_PREV),
        .sum    (ROW_SUM)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model state: what the outputs must show in the current cycle.
    bit           m_valid  = 1'b0;
    bit           m_active = 1'b0;
    int           m_k      = 0;
    int           m_lat    = 0;
    logic [W-1:0] m_hi, m_lo, m_x, p_hi, p_lo;
    logic         m_dz, m_mb, p_dz;

    // Compare the DUT against the model, then advance the model with the
    // inputs that the coming rising edge will sample.
    initial begin
        int prod;
        int rs;
        bit run_e;
        forever begin
            @(negedge CLK);
            if (m_valid) begin
                run_e = m_active && m_k >= 2 && m_k < m_lat;
                check("busy",      BUSY,      m_active && m_k < m_lat);
                check("done",      DONE,      m_active && m_k == m_lat);
                check("div_zero",  DIV_ZERO,  m_dz);
                check("result_hi", RESULT_HI, m_hi);
                check("result_lo", RESULT_LO, m_lo);
                check("row_x",     ROW_X,     m_x);
                check("row_mul_bar", ROW_MUL_BAR, m_mb);
                if (!run_e) check("row_yp_quiet", {ROW_Y, ROW_P}, 2'b00);
                if (run_e && m_mb == OP_MUL) check("row_p_mul", ROW_P, 1'b0);
                if (run_e && m_mb == OP_DIV && m_k < m_lat - 1) check("row_y_div", ROW_Y, 1'b1);
                rs = int'(ROW_IN_PREV) + (ROW_Y ? (ROW_P ? -int'(ROW_X) : int'(ROW_X)) : 0);
                check("row_sum", ROW_SUM, rs & ((1 << (W + 1)) - 1));
            end

            if (RST === 1'b1) begin
                m_valid  = 1'b1;
                m_active = 1'b0;
                m_hi = '0; m_lo = '0; m_dz = 1'b0; m_mb = 1'b0; m_x = '0;
            end else if (m_valid) begin
                if (m_active) begin
                    if (m_k == m_lat) m_active = 1'b0;
                    else begin
                        m_k++;
                        if (m_k == m_lat) begin
                            m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
                        end
                    end
                end else if (START === 1'b1) begin
                    m_active = 1'b1;
                    m_k      = 1;
                    m_mb     = MUL_BAR;
                    m_x      = X_IN;
                    m_dz     = 1'b0;
                    if (MUL_BAR == OP_MUL) begin
                        prod  = int'(X_IN) * int'(Y_IN);
                        p_hi  = W'(prod >> W);
                        p_lo  = W'(prod);
                        p_dz  = 1'b0;
                        m_lat = W + 2;
                    end else if (X_IN == '0) begin
                        p_hi  = Y_IN;
                        p_lo  = '1;
                        p_dz  = 1'b1;
                        m_lat = 2;
                    end else begin
                        p_hi  = Y_IN % X_IN;
                        p_lo  = Y_IN / X_IN;
                        p_dz  = 1'b0;
                        m_lat = W + 3;
                    end
                end
            end
        end
    end

    // One operation: pulse START, wait (bounded) for DONE, check latency and,
    // when pin is set, the hand-computed results. repulse_at re-asserts START
    // during that cycle count of the operation.
    task automatic run_op(input logic mb, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit pin, input logic [W-1:0] hi, input logic [W-1:0] lo,
                          input logic dz, input int repulse_at, input string name);
        int n;
        int lat_e;
        lat_e   = (mb == OP_MUL) ? W + 2 : ((x == '0) ? 2 : W + 3);
        MUL_BAR = mb;
        X_IN    = x;
        Y_IN    = y;
        START   = 1'b1;
        @(posedge CLK); #1;
        START   = 1'b0;
        MUL_BAR = 1'($urandom);
        X_IN    = W'($urandom);
        Y_IN    = W'($urandom);
        n = 1;
        while (DONE !== 1'b1 && n < 40) begin
            START = (n == repulse_at);
            @(posedge CLK); #1;
            n++;
        end
        START = 1'b0;
        check({name, "_latency"}, n, lat_e);
        if (pin) begin
            check({name, "_hi"}, RESULT_HI, hi);
            check({name, "_lo"}, RESULT_LO, lo);
            check({name, "_dz"}, DIV_ZERO, dz);
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        logic         mb;
        logic [W-1:0] x, y;
        RST = 1'b1; START = 1'b0; MUL_BAR = 1'b0; X_IN = '0; Y_IN = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy", BUSY, 1'b0);
        check("rst_done", DONE, 1'b0);
        check("rst_results", {DIV_ZERO, RESULT_HI, RESULT_LO}, '0);
        check("rst_row", {ROW_X, ROW_Y, ROW_P, ROW_MUL_BAR, ROW_IN_PREV}, '0);
        RST = 1'b0;

        run_op(OP_MUL, 4'd13, 4'd11, 1'b1, 4'd8, 4'd15, 1'b0, 0, "mul_13x11");
        run_op(OP_DIV, 4'd3,  4'd13, 1'b1, 4'd1, 4'd4,  1'b0, 0, "div_13by3");
        run_op(OP_DIV, 4'd5,  4'd3,  1'b1, 4'd3, 4'd0,  1'b0, 0, "div_3by5");
        run_op(OP_DIV, 4'd0,  4'd9,  1'b1, 4'd9, 4'd15, 1'b1, 0, "div_by_zero");
        repeat (3) @(posedge CLK);
        #1;
        check("div_zero_held", DIV_ZERO, 1'b1);
        run_op(OP_MUL, 4'd15, 4'd15, 1'b1, 4'd14, 4'd1, 1'b0, 3, "mul_15x15_repulse");
        run_op(OP_MUL, 4'd0,  4'd9,  1'b1, 4'd0, 4'd0,  1'b0, 0, "mul_0x9");
        run_op(OP_DIV, 4'd1,  4'd11, 1'b1, 4'd0, 4'd11, 1'b0, 0, "div_11by1");
        run_op(OP_MUL, 4'd15, 4'd15, 1'b1, 4'd14, 4'd1, 1'b0, 0, "mul_15x15");

        // Reset in the middle of 7*6 aborts and clears the held 225.
        MUL_BAR = OP_MUL; X_IN = 4'd7; Y_IN = 4'd6; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("abort_busy", BUSY, 1'b0);
        check("abort_results", {RESULT_HI, RESULT_LO}, '0);
        run_op(OP_MUL, 4'd2, 4'd3, 1'b1, 4'd0, 4'd6, 1'b0, 0, "mul_2x3_after_abort");

        // Reset together with START: reset wins, nothing starts.
        RST = 1'b1; START = 1'b1; MUL_BAR = OP_MUL; X_IN = 4'd5; Y_IN = 4'd5;
        @(posedge CLK); #1;
        RST = 1'b0; START = 1'b0;
        check("rst_start_busy0", BUSY, 1'b0);
        @(posedge CLK); #1;
        check("rst_start_busy1", BUSY, 1'b0);

        for (int i = 0; i < 40; i++) begin
            mb = 1'($urandom_range(0, 1));
            x  = W'($urandom_range(0, (1 << W) - 1));
            y  = W'($urandom_range(0, (1 << W) - 1));
            run_op(mb, x, y, 1'b0, '0, '0, 1'b0, (i % 5 == 0) ? 2 : 0, "random");
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            #1;
        end

        repeat (2) @(posedge CLK);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
